cpu_run_ctrl: RTL and testbench

//  Run/halt/step sequencer and program-load arbiter for the 8-bit demo CPU core.

---
 rtl/cpu_ctrl_pkg.sv | 13 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/cpu_run_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared state codes for the demo CPU run/halt/step/load sequencer.
package cpu_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-FF synchroniser, stable-for-DEBOUNCE filter,
// and a one-clk event on the released->pressed transition of the filtered level.
module btn_debounce #(
  parameter int DEBOUNCE = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press_ev,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // level is 1 while pressed; cnt counts consecutive samples that disagree with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      level    <= 1'b0;
      press_ev <= 1'b0;
    end else begin
      sync1    <= ~raw_n;
      sync2    <= sync1;
      press_ev <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt      <= '0;
        level    <= sync2;
        press_ev <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer and program-load arbiter for the 8-bit demo CPU.
// Loader owns the program RAM write port only while the CPU is held in LOAD.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PERIOD   = 2097152,
  parameter int DEBOUNCE = 270000,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run_n,
  input  logic              btn_step_n,
  input  logic              btn_load_n,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_step,
  output logic              cpu_rst_n,
  output logic [ST_W-1:0]   state,
  output logic [7:0]        ld_count
);

  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PERIOD - 1);

  logic          run_ev;
  logic          step_ev;
  logic          load_ev;
  logic          unused_run_level;
  logic          unused_step_level;
  logic          unused_load_level;
  state_t        st;
  logic [PW-1:0] presc;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_run (
    .clk      (clk),
    .rst      (rst),
    .raw_n    (btn_run_n),
    .press_ev (run_ev),
    .level    (unused_run_level)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_step (
    .clk      (clk),
    .rst      (rst),
    .raw_n    (btn_step_n),
    .press_ev (step_ev),
    .level    (unused_step_level)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_load (
    .clk      (clk),
    .rst      (rst),
    .raw_n    (btn_load_n),
    .press_ev (load_ev),
    .level    (unused_load_level)
  );

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= ST_HALT;
      presc     <= '0;
      cpu_step  <= 1'b0;
      cpu_rst_n <= 1'b0;
      ld_ready  <= 1'b0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ld_count  <= 8'd0;
    end else begin
      cpu_step  <= 1'b0;
      ram_we    <= 1'b0;
      cpu_rst_n <= 1'b1;

      // ld_ready is only high in LOAD, so this also covers the write accepted on the exit edge
      if (ld_valid && ld_ready) begin
        ram_we    <= 1'b1;
        ram_waddr <= ld_addr;
        ram_wdata <= ld_data;
        ld_count  <= ld_count + 8'd1;
      end

      case (st)
        ST_HALT: begin
          if (load_ev) begin
            st        <= ST_LOAD;
            ld_count  <= 8'd0;
            ld_ready  <= 1'b1;
            cpu_rst_n <= 1'b0;
          end else if (run_ev) begin
            st    <= ST_RUN;
            presc <= '0;
          end else if (step_ev) begin
            st       <= ST_STEP;
            cpu_step <= 1'b1;
          end
        end
        ST_RUN: begin
          if (run_ev) begin
            st <= ST_HALT;
          end else if (presc == PRESC_MAX) begin
            presc    <= '0;
            cpu_step <= 1'b1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        ST_STEP: begin
          st <= ST_HALT;
        end
        ST_LOAD: begin
          // CPU stays in reset through the exit cycle so the final write lands first
          cpu_rst_n <= 1'b0;
          if (load_ev) begin
            st       <= ST_HALT;
            ld_ready <= 1'b0;
          end
        end
        default: st <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: event table, RUN/STEP timing, load scoreboard, reset mid-LOAD.
module tb_cpu_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run_n, btn_step_n, btn_load_n;
  logic       ld_valid;
  logic [7:0] ld_addr, ld_data;
  logic       ld_ready, ram_we, cpu_step, cpu_rst_n;
  logic [7:0] ram_waddr, ram_wdata, ld_count;
  logic [1:0] state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pulse_cnt = 0;
  logic [15:0] sb[$];
  logic [1:0]  prev_state = 2'd0;

  typedef struct {
    logic [2:0] press;  // {load, run, step}
    logic [1:0] st;
    logic       rdy;
    logic       rn;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PERIOD(8), .DEBOUNCE(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_run_n  (btn_run_n),
    .btn_step_n (btn_step_n),
    .btn_load_n (btn_load_n),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .cpu_step   (cpu_step),
    .cpu_rst_n  (cpu_rst_n),
    .state      (state),
    .ld_count   (ld_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(input logic [2:0] m);
    btn_load_n = ~m[2];
    btn_run_n  = ~m[1];
    btn_step_n = ~m[0];
  endtask

  task automatic release_btn();
    set_btn(3'b000);
  endtask

  task automatic wait_state(input logic [1:0] t, input string name);
    for (int i = 0; i < 40 && state !== t; i++) tick();
    chk(name, 32'(state), 32'(t));
  endtask

  // Scoreboard: a handshake seen this cycle must appear on the RAM port next cycle
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (cpu_step) begin
        pulse_cnt++;
        chk("step_not_in_load", 32'(state != 2'd3), 32'd1);
      end
      if (ram_we) begin
        chk("we_in_load_window", 32'((state == 2'd3) || (prev_state == 2'd3)), 32'd1);
        chk("we_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("we_addr_data", 32'({ram_waddr, ram_wdata}), 32'(sb.pop_front()));
      end
      if (ld_valid && ld_ready) sb.push_back({ld_addr, ld_data});
    end
    prev_state = state;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] la[3];
    logic [7:0] ldat[3];
    int p0, k;
    la   = '{8'h00, 8'h01, 8'h02};
    ldat = '{8'hA6, 8'hF0, 8'h66};

    tbl[0]  = '{3'b010, 2'd1, 1'b0, 1'b1};
    tbl[1]  = '{3'b001, 2'd1, 1'b0, 1'b1};
    tbl[2]  = '{3'b100, 2'd1, 1'b0, 1'b1};
    tbl[3]  = '{3'b010, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{3'b011, 2'd1, 1'b0, 1'b1};
    tbl[5]  = '{3'b010, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{3'b110, 2'd3, 1'b1, 1'b0};
    tbl[7]  = '{3'b001, 2'd3, 1'b1, 1'b0};
    tbl[8]  = '{3'b010, 2'd3, 1'b1, 1'b0};
    tbl[9]  = '{3'b100, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{3'b101, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{3'b100, 2'd0, 1'b0, 1'b1};

    rst = 1'b0;
    release_btn();
    ld_valid = 1'b0;
    ld_addr  = 8'h00;
    ld_data  = 8'h00;

    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_step", 32'(cpu_step), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ld_count", 32'(ld_count), 32'd0);
    tick();
    rst = 1'b1;
    chk("rst_n_before_clk", 32'(cpu_rst_n), 32'd0);
    tick();
    chk("rst_n_after_clk", 32'(cpu_rst_n), 32'd1);

    foreach (tbl[i]) begin
      set_btn(tbl[i].press);
      ticks(10);
      release_btn();
      ticks(10);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_cpu_rst_n", i), 32'(cpu_rst_n), 32'(tbl[i].rn));
    end

    // RUN strobe timing: first pulse 8 clk after entry, then every 8
    set_btn(3'b010);
    wait_state(2'd1, "run_enter");
    k = 0;
    for (int j = 1; j <= 20 && k == 0; j++) begin
      tick();
      if (cpu_step) k = j;
    end
    chk("run_first_pulse_gap", 32'(k), 32'd8);
    k = 0;
    for (int j = 1; j <= 20 && k == 0; j++) begin
      tick();
      if (cpu_step) k = j;
    end
    chk("run_second_pulse_gap", 32'(k), 32'd8);
    release_btn();
    ticks(10);
    set_btn(3'b010);
    wait_state(2'd0, "run_stop");
    release_btn();
    p0 = pulse_cnt;
    ticks(30);
    chk("halt_no_pulses", 32'(pulse_cnt - p0), 32'd0);

    // STEP with a long hold: exactly one pulse per press
    for (int r = 0; r < 2; r++) begin
      p0 = pulse_cnt;
      set_btn(3'b001);
      ticks(50);
      release_btn();
      ticks(10);
      chk($sformatf("step%0d_pulses", r), 32'(pulse_cnt - p0), 32'd1);
      chk($sformatf("step%0d_state", r), 32'(state), 32'd0);
    end

    // LOAD session: three back-to-back bytes
    set_btn(3'b100);
    wait_state(2'd3, "load_enter");
    chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("load_ld_ready", 32'(ld_ready), 32'd1);
    release_btn();
    ticks(10);
    chk("load_count_start", 32'(ld_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_addr  = la[i];
      ld_data  = ldat[i];
      tick();
      chk($sformatf("load_we%0d", i), 32'(ram_we), 32'd1);
      chk($sformatf("load_waddr%0d", i), 32'(ram_waddr), 32'(la[i]));
      chk($sformatf("load_wdata%0d", i), 32'(ram_wdata), 32'(ldat[i]));
    end
    ld_valid = 1'b0;
    tick();
    chk("load_we_idle", 32'(ram_we), 32'd0);
    chk("load_count3", 32'(ld_count), 32'd3);

    // Exit with the loader still pushing: last accepted byte lands in the exit cycle
    ld_valid = 1'b1;
    ld_addr  = 8'h40;
    ld_data  = 8'h5A;
    set_btn(3'b100);
    wait_state(2'd0, "load_exit");
    chk("exit_ld_ready", 32'(ld_ready), 32'd0);
    chk("exit_inflight_we", 32'(ram_we), 32'd1);
    chk("exit_cpu_rst_n_low", 32'(cpu_rst_n), 32'd0);
    tick();
    chk("exit_cpu_rst_n_high", 32'(cpu_rst_n), 32'd1);
    chk("exit_we_done", 32'(ram_we), 32'd0);
    ld_valid = 1'b0;
    release_btn();
    ticks(10);

    // Reset in the middle of a LOAD burst
    set_btn(3'b100);
    wait_state(2'd3, "rl_enter");
    release_btn();
    ticks(10);
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_addr = 8'h10 + 8'(i);
      ld_data = 8'hC0 + 8'(i);
      tick();
    end
    #3 rst = 1'b0;
    #1;
    chk("rl_state", 32'(state), 32'd0);
    chk("rl_ram_we", 32'(ram_we), 32'd0);
    chk("rl_ld_ready", 32'(ld_ready), 32'd0);
    chk("rl_ld_count", 32'(ld_count), 32'd0);
    chk("rl_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rl_post_we%0d", i), 32'(ram_we), 32'd0);
    end
    chk("rl_post_state", 32'(state), 32'd0);
    ld_valid = 1'b0;
    ticks(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
